// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: bundle of every signal that crosses the RAM arbiter
// boundary except clock and reset.
//   Requester side (per port N = 0,1):
//     reqN, weN, addrN, wdataN  -> request, held stable until doneN
//     gntN, doneN, rdataN       <- grant during ACCESS, completion pulse, read data
//   Control:
//     enable                    -> gates new grants only
//   RAM side:
//     addressbus, toram, read, write -> registered RAM drive
//     fromram                   <- combinational RAM read data
// Modports:
//   slave  - the arbiter's view
//   master - the environment's view (requesters plus the RAM block)
interface ram_arbiter_if #(
    parameter int adlines   = 8,
    parameter int datalines = 16
);
    logic                 enable;
    logic                 req0, req1;
    logic                 we0, we1;
    logic [adlines-1:0]   addr0, addr1;
    logic [datalines-1:0] wdata0, wdata1;
    logic                 gnt0, gnt1;
    logic                 done0, done1;
    logic [datalines-1:0] rdata0, rdata1;
    logic [adlines-1:0]   addressbus;
    logic [datalines-1:0] toram;
    logic [datalines-1:0] fromram;
    logic                 read, write;

    modport slave (
        input  enable, req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, fromram,
        output gnt0, gnt1, done0, done1, rdata0, rdata1, addressbus, toram, read, write
    );

    modport master (
        output enable, req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, fromram,
        input  gnt0, gnt1, done0, done1, rdata0, rdata1, addressbus, toram, read, write
    );
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one RAM block between the control unit (port 0) and a
// program/data loader (port 1). One transaction at a time, round-robin on
// ties. Each transaction is a single registered RAM access cycle followed by
// a one-cycle completion pulse carrying read data back to the requester.
// Ports:
//   clk    - rising-edge clock
//   resetn - asynchronous active-low reset
//   bus    - ram_arbiter_if.slave (requests, grants, completions, RAM drive)

// Per-port completion logic: registers the done pulse and captures read
// data when this port's read access finishes.
module ram_arbiter_lane #(
    parameter int datalines = 16
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 fin,      // this port's ACCESS cycle ends at this edge
    input  logic                 rd,       // the finishing access is a read
    input  logic [datalines-1:0] fromram,
    output logic                 done,
    output logic [datalines-1:0] rdata
);
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            done  <= 1'b0;
            rdata <= '0;
        end else begin
            done <= fin;
            // Writes leave rdata alone; it holds the last completed read.
            if (fin && rd)
                rdata <= fromram;
        end
    end
endmodule

module ram_arbiter #(
    parameter int adlines   = 8,
    parameter int datalines = 16
) (
    input  logic         clk,
    input  logic         resetn,
    ram_arbiter_if.slave bus
);
    typedef enum logic {IDLE, ACCESS} state_t;

    state_t                         state;
    logic                           last;     // port granted most recently
    logic                           owner;    // port owning the current access
    logic [1:0]                     gnt_q;
    logic                           read_q, write_q;
    logic [adlines-1:0]             addr_q;
    logic [datalines-1:0]           toram_q;

    logic [1:0]                     req, we, fin, done;
    logic [1:0][adlines-1:0]        addr;
    logic [1:0][datalines-1:0]      wdata, rdata;
    logic                           win;

    assign req   = {bus.req1, bus.req0};
    assign we    = {bus.we1, bus.we0};
    assign addr  = {bus.addr1, bus.addr0};
    assign wdata = {bus.wdata1, bus.wdata0};

    // Lone requester wins; on a tie the port that did not go last wins.
    always_comb begin
        win = req[1];
        if (req == 2'b11)
            win = ~last;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            last    <= 1'b1;   // port 0 takes the first tie
            owner   <= 1'b0;
            gnt_q   <= 2'b00;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            addr_q  <= '0;
            toram_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.enable && (req != 2'b00)) begin
                        addr_q  <= addr[win];
                        toram_q <= wdata[win];   // driven on reads too; RAM ignores it
                        write_q <= we[win];
                        read_q  <= ~we[win];
                        gnt_q   <= win ? 2'b10 : 2'b01;
                        last    <= win;
                        owner   <= win;
                        state   <= ACCESS;
                    end else begin
                        // Bus lines hold; only strobes and grants drop.
                        gnt_q   <= 2'b00;
                        read_q  <= 1'b0;
                        write_q <= 1'b0;
                    end
                end
                ACCESS: begin
                    // enable is not consulted: an access always completes.
                    gnt_q   <= 2'b00;
                    read_q  <= 1'b0;
                    write_q <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Decoded from registered state, so done/rdata stay registered outputs.
    assign fin[0] = (state == ACCESS) && (owner == 1'b0);
    assign fin[1] = (state == ACCESS) && (owner == 1'b1);

    for (genvar g = 0; g < 2; g++) begin : g_lane
        ram_arbiter_lane #(.datalines(datalines)) u_lane (
            .clk     (clk),
            .resetn  (resetn),
            .fin     (fin[g]),
            .rd      (read_q),
            .fromram (bus.fromram),
            .done    (done[g]),
            .rdata   (rdata[g])
        );
    end

    assign bus.gnt0       = gnt_q[0];
    assign bus.gnt1       = gnt_q[1];
    assign bus.done0      = done[0];
    assign bus.done1      = done[1];
    assign bus.rdata0     = rdata[0];
    assign bus.rdata1     = rdata[1];
    assign bus.addressbus = addr_q;
    assign bus.toram      = toram_q;
    assign bus.read       = read_q;
    assign bus.write      = write_q;
endmodule
